uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Transmit-side buffer between mmio_peripherals and the uart core; it is the upstream counterpart of the RX circular buffer. Firmware writes bytes into the FIFO without polling uart busy. An internal FSM drains the FIFO into the uart core using the core's tx_ena/tx_busy handshake: it pulses tx_ena once per byte. It reports a drained pulse, a sticky overflow flag and a sticky handshake error.

Parameters:
DATA_WIDTH, 8, byte width of FIFO entries and tx_data
ADDR_BITS, 4, log2 FIFO depth (default depth 16)
BUSY_WAIT, 4, cycles allowed after a tx_ena pulse for tx_busy to rise before the handshake is declared failed (range 1..15)

Ports:
clk  in  1  system clock (50 MHz domain)
reset  in  1  synchronous, active-high reset
wr_en  in  1  push wr_data (from MMIO TX register write)
wr_data  in  DATA_WIDTH  byte to enqueue
clear  in  1  flush queued bytes, clear sticky flags
full  out  1  FIFO holds 2^ADDR_BITS entries
empty  out  1  FIFO holds 0 entries
level  out  ADDR_BITS+1  current occupancy
overflow  out  1  sticky: a push was attempted while full
tx_err  out  1  sticky: tx_busy never rose within BUSY_WAIT cycles
drained  out  1  one-cycle pulse: last byte finished and FIFO empty
tx_ena  out  1  to uart core, one-cycle launch pulse
tx_data  out  DATA_WIDTH  to uart core, held stable from launch until return to IDLE
tx_busy  in  1  from uart core, high while a frame is shifting

Behaviour:
- Reset (sync, active-high, one cycle is sufficient): pointers and level=0, empty=1, full=0, overflow=0, tx_err=0, drained=0, tx_ena=0, tx_data=0, FSM=IDLE.
- FIFO: registered pointers with ADDR_BITS+1 bits; wrap is natural modulo; full when MSBs differ and lower bits are equal. level = wr_ptr - rd_ptr.
- Push when wr_en && !full. A push attempted while full is dropped, sets overflow, and leaves the stored data unchanged.
- A pop occurs only on the FSM IDLE->LAUNCH transition. Push and pop in the same cycle: level unchanged, both take effect. This includes the case where the FIFO is full, because the pop frees a slot in the same cycle.
- FSM states:
  - IDLE: if !empty && !tx_busy, pop the head into tx_data and go to LAUNCH.
  - LAUNCH: tx_ena=1 for exactly this cycle; load the wait counter with BUSY_WAIT; go to WAIT_BUSY.
  - WAIT_BUSY: if tx_busy, go to WAIT_DONE. Otherwise decrement the counter; at 0, set tx_err and go to IDLE (the byte is lost, no retry).
  - WAIT_DONE: on tx_busy==0, go to IDLE. If the FIFO is empty and there is no push this cycle, pulse drained.
- Latency: a push at cycle N into an empty FIFO with the uart idle gives empty=0 at N+1, the pop at N+1, and tx_ena=1 at N+2. Back-to-back bytes: the next tx_ena comes 2 cycles after tx_busy falls.
- clear (no reset): resets the pointers and the sticky flags. It does not abort the frame in flight; the FSM finishes WAIT_BUSY/WAIT_DONE normally. A push coinciding with clear is discarded. drained is suppressed on the frame that completes after clear.
- tx_ena is never asserted while tx_busy is high.

Decomposition:
- Shared package uart_tx_pkg: state encoding constants (IDLE=2'd0, LAUNCH=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3) and the default depth constant.
- One sub-module, uart_tx_fifo_mem: 2^ADDR_BITS x DATA_WIDTH register array with synchronous write and asynchronous read (inferable as LUT RAM). Pointer, flag and FSM logic stay in the top module.

Test Plan:
- Reset then single push 8'h41, uart model raises tx_busy 1 cycle after tx_ena for 160 cycles -> tx_ena at push+2, tx_data=8'h41, one drained pulse when busy falls, level returns to 0.
- 16 pushes (0x00..0x0F) then a 17th push of 0xFF with the uart stalled busy -> full=1, overflow=1, 0xFF never transmitted, bytes emitted in order 0x00..0x0F.
- Push while full in the same cycle as the FSM pop -> push accepted, overflow stays 0, level stays 16.
- Uart model never asserts tx_busy after tx_ena, BUSY_WAIT=4 -> tx_err=1 5 cycles after tx_ena, FSM back in IDLE, next byte launched afterwards.
- clear asserted during WAIT_DONE with 5 bytes queued -> level=0 next cycle, current frame completes, no further tx_ena, no drained pulse.
- reset asserted mid-WAIT_DONE -> all outputs at their reset values next cycle; first push after reset launches normally at push+2.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and constants for the uart transmit FIFO.
// Drain FSM state encoding and default buffer geometry.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int DEF_DEPTH = 16;
  localparam int WAIT_W    = 4;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// uart_tx_fifo_mem: FIFO storage array.
// Synchronous write, asynchronous read so it maps onto LUT RAM.
module uart_tx_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of the uart core, drained by a
// small FSM over the tx_ena / tx_busy handshake.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = $clog2(DEF_DEPTH),
  parameter int BUSY_WAIT  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clear,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_BITS:0]    level,
  output logic                  overflow,
  output logic                  tx_err,
  output logic                  drained,
  output logic                  tx_ena,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_busy
);

  logic [ADDR_BITS:0]    wr_ptr;
  logic [ADDR_BITS:0]    rd_ptr;
  logic [DATA_WIDTH-1:0] head;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  no_drain;
  logic                  push;
  logic                  pop;
  logic                  timeout;
  logic                  done;
  state_t                state;
  state_t                state_nx;

  uart_tx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[ADDR_BITS-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[ADDR_BITS-1:0]),
    .rdata (head)
  );

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                 (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
  assign level = wr_ptr - rd_ptr;

  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign pop  = (state == IDLE) && !empty && !tx_busy && !clear;
  assign push = wr_en && !clear && (!full || pop);

  assign tx_ena = (state == LAUNCH);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    timeout  = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pop) state_nx = LAUNCH;
      end
      LAUNCH: begin
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nx = WAIT_DONE;
        end else if (wait_cnt == WAIT_W'(1)) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      tx_err   <= 1'b0;
      drained  <= 1'b0;
      tx_data  <= '0;
      wait_cnt <= '0;
      no_drain <= 1'b0;
    end else begin
      drained <= done && empty && !push && !clear && !no_drain;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (clear)              overflow <= 1'b0;
      else if (wr_en && !push) overflow <= 1'b1;
      if (clear)        tx_err <= 1'b0;
      else if (timeout) tx_err <= 1'b1;
      if (pop) tx_data <= head;
      if (tx_ena)                 wait_cnt <= WAIT_W'(BUSY_WAIT);
      else if (state == WAIT_BUSY) wait_cnt <= wait_cnt - 1'b1;
      // a frame still in flight across a clear must not report drained
      if (clear && state != IDLE) no_drain <= 1'b1;
      else if (state == IDLE)     no_drain <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios plus a randomized run checked
// against a queue model of the FIFO and a simple uart core model.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clear;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       tx_err;
  logic       drained;
  logic       tx_ena;
  logic [7:0] tx_data;
  logic       tx_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic busy_r = 1'b0;
  int   bcnt = 0;
  bit   stall = 1'b0;
  bit   no_ack = 1'b0;
  bit   rand_len = 1'b0;
  int   flen = 1;

  logic [7:0] sent[$];
  int         launch_cyc[$];
  int         n_drained = 0;
  int         drained_cyc = 0;
  int         fall_cyc = 0;
  logic       busy_prev = 1'b0;

  uart_tx_fifo #(
    .DATA_WIDTH (8),
    .ADDR_BITS  (4),
    .BUSY_WAIT  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clear    (clear),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_err   (tx_err),
    .drained  (drained),
    .tx_ena   (tx_ena),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign tx_busy = busy_r | stall;

  // uart core: busy one cycle after tx_ena, for flen cycles
  always @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      bcnt   <= 0;
    end else if (tx_ena && !no_ack) begin
      busy_r <= 1'b1;
      bcnt   <= rand_len ? int'($urandom_range(7, 0)) : flen - 1;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end else begin
      busy_r <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_ena) begin
        sent.push_back(tx_data);
        launch_cyc.push_back(cyc);
        check("ena_while_busy", 32'(busy_r), 32'(0));
      end
      if (drained) begin
        n_drained++;
        drained_cyc = cyc;
      end
      if (busy_prev && !busy_r) fall_cyc = cyc;
    end
    busy_prev = busy_r;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic push1(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int budget);
    int k = 0;
    while (sent.size() < n && k < budget) begin
      step();
      k++;
    end
    if (sent.size() < n) check("timeout_launch", 32'(sent.size()), 32'(n));
  endtask

  task automatic wait_drained(input int n, input int budget);
    int k = 0;
    while (n_drained < n && k < budget) begin
      step();
      k++;
    end
    if (n_drained < n) check("timeout_drained", 32'(n_drained), 32'(n));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_level"}, 32'(level), 32'(0));
    check({tag, "_empty"}, 32'(empty), 32'(1));
    check({tag, "_full"}, 32'(full), 32'(0));
    check({tag, "_ovf"}, 32'(overflow), 32'(0));
    check({tag, "_err"}, 32'(tx_err), 32'(0));
    check({tag, "_drained"}, 32'(drained), 32'(0));
    check({tag, "_ena"}, 32'(tx_ena), 32'(0));
    check({tag, "_data"}, 32'(tx_data), 32'(0));
  endtask

  task automatic start_test();
    sent.delete();
    launch_cyc.delete();
    n_drained = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         pc;
    int         t;
    logic [7:0] q[$];
    logic [7:0] expq[$];
    logic [7:0] hd;
    logic [7:0] prev_d;
    bit         prev_wr;
    bit         ovf_m;

    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    clear   = 1'b0;
    steps(2);
    reset = 1'b0;
    check_reset_outs("rst");

    // single byte, long frame
    start_test();
    flen = 160;
    step();
    pc = cyc;
    push1(8'h41);
    check("single_empty", 32'(empty), 32'(0));
    wait_sent(1, 10);
    check("single_lat", 32'(launch_cyc[0] - pc), 32'(2));
    check("single_data", 32'(sent[0]), 32'h41);
    wait_drained(1, 300);
    check("single_drain_t", 32'(drained_cyc - fall_cyc), 32'(1));
    steps(3);
    check("single_drain_n", 32'(n_drained), 32'(1));
    check("single_level", 32'(level), 32'(0));

    // fill to full with uart stalled, then overflow
    start_test();
    flen  = 3;
    stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    check("fill_full", 32'(full), 32'(1));
    check("fill_level", 32'(level), 32'(16));
    check("fill_ovf0", 32'(overflow), 32'(0));
    push1(8'hFF);
    check("ovf_set", 32'(overflow), 32'(1));
    check("ovf_level", 32'(level), 32'(16));
    stall = 1'b0;
    wait_sent(16, 400);
    for (int i = 0; i < 16; i++) check("fill_order", 32'(sent[i]), 32'(i));
    wait_drained(1, 100);
    check("fill_count", 32'(sent.size()), 32'(16));
    check("ovf_sticky", 32'(overflow), 32'(1));
    pulse_clear();
    check("ovf_clear", 32'(overflow), 32'(0));

    // push while full in the same cycle as the pop
    start_test();
    expq.delete();
    stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h80 + 8'(i);
      expq.push_back(8'h80 + 8'(i));
      step();
    end
    expq.push_back(8'hAA);
    stall   = 1'b0;
    wr_data = 8'hAA;
    step();
    wr_en = 1'b0;
    check("pp_level", 32'(level), 32'(16));
    check("pp_ovf", 32'(overflow), 32'(0));
    wait_sent(17, 600);
    for (int i = 0; i < 17; i++) check("pp_order", 32'(sent[i]), 32'(expq[i]));
    wait_drained(1, 100);

    // uart never acknowledges
    start_test();
    no_ack = 1'b1;
    push1(8'h11);
    push1(8'h22);
    wait_sent(1, 10);
    t = launch_cyc[0];
    check("err_t0", 32'(tx_err), 32'(0));
    steps(4);
    check("err_t4", 32'(tx_err), 32'(0));
    step();
    check("err_t5", 32'(tx_err), 32'(1));
    wait_sent(2, 20);
    check("err_next_lat", 32'(launch_cyc[1] - t), 32'(6));
    check("err_next_data", 32'(sent[1]), 32'h22);
    steps(10);
    check("err_no_drain", 32'(n_drained), 32'(0));
    check("err_empty", 32'(empty), 32'(1));
    no_ack = 1'b0;
    pulse_clear();
    check("err_clear", 32'(tx_err), 32'(0));

    // clear during WAIT_DONE with 5 queued
    start_test();
    flen = 20;
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h30 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    check("clr_level5", 32'(level), 32'(5));
    pulse_clear();
    check("clr_level0", 32'(level), 32'(0));
    check("clr_empty", 32'(empty), 32'(1));
    steps(30);
    check("clr_sent", 32'(sent.size()), 32'(1));
    check("clr_no_drain", 32'(n_drained), 32'(0));
    check("clr_frame_done", 32'(busy_r), 32'(0));

    // reset in WAIT_DONE
    start_test();
    flen = 30;
    push1(8'h5A);
    wait_sent(1, 10);
    steps(5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_outs("mid_rst");
    step();
    start_test();
    pc = cyc;
    push1(8'h66);
    wait_sent(1, 10);
    check("rst_lat", 32'(launch_cyc[0] - pc), 32'(2));
    check("rst_data", 32'(sent[0]), 32'h66);
    wait_drained(1, 100);

    // randomized traffic against a queue model
    reset = 1'b1;
    step();
    reset    = 1'b0;
    rand_len = 1'b1;
    q.delete();
    ovf_m   = 1'b0;
    prev_wr = 1'b0;
    prev_d  = '0;
    for (int it = 0; it < 900; it++) begin
      step();
      if (tx_ena) begin
        check("rnd_avail", 32'(q.size() > 0), 32'(1));
        if (q.size() > 0) begin
          hd = q.pop_front();
          check("rnd_data", 32'(tx_data), 32'(hd));
        end
      end
      if (prev_wr) begin
        if (q.size() < 16) q.push_back(prev_d);
        else ovf_m = 1'b1;
      end
      check("rnd_level", 32'(level), 32'(q.size()));
      check("rnd_ovf", 32'(overflow), 32'(ovf_m));
      check("rnd_full", 32'(full), 32'(q.size() == 16));
      prev_wr = (it < 500) && ($urandom_range(99, 0) < 55);
      prev_d  = 8'($urandom);
      wr_en   = prev_wr;
      wr_data = prev_d;
    end
    check("rnd_drained_all", 32'(q.size()), 32'(0));
    check("rnd_tx_err", 32'(tx_err), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
